ahb_perf_timer: RTL and testbench

AHB_PERF_TIMER -- requirements
Module: ahb_perf_timer

---
 rtl/ahb_perf_pkg.sv | 34 +++
 rtl/ahb_perf_timer_if.sv | 22 ++
 rtl/perf_seg_digit.sv | 16 +
 rtl/ahb_perf_timer.sv | 218 +++++++++++++++++++++
 tb/tb_ahb_perf_timer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_perf_pkg.sv
// Shared types and constants for the AHB performance timer: FSM states,
// register offsets, CTRL bit positions and the 7-segment code table.
package ahb_perf_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    FINISHED = 2'd2
  } state_e;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_DONE   = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_TIME   = 3'd3;
  localparam logic [2:0] REG_LAP    = 3'd4;
  localparam logic [2:0] REG_PIXEL  = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CLEAR = 2;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  // Active-low segment codes, entry [d] is the code for decimal digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [6:0] SEG_INVALID = 7'h01;

  function automatic logic [31:0] pack_time(logic [3:0] ds, logic [5:0] sec, logic [3:0] mins);
    return {12'd0, mins, 2'd0, sec, 4'd0, ds};
  endfunction

endpackage

// File: rtl/ahb_perf_timer_if.sv
// AHB-Lite slave-side bus bundle for the performance timer.
interface ahb_perf_timer_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport slave (
    input  HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL,
    output HRDATA, HREADYOUT
  );

  modport master (
    output HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL,
    input  HRDATA, HREADYOUT
  );
endinterface

// File: rtl/perf_seg_digit.sv
// One 7-segment digit decoder: 0..9 map through the package table,
// anything larger shows the "invalid" pattern.
module perf_seg_digit
  import ahb_perf_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  // NOTE: o_seg is given a value before the conditional so no latch is inferred.
  always_comb begin
    o_seg = SEG_INVALID;
    if (i_val <= 4'd9) o_seg = SEG_TABLE[i_val];
  end

endmodule

// File: rtl/ahb_perf_timer.sv
// AHB-Lite stopwatch timing NCORES completion reports, with 7-segment outputs.
// Optional LAP register is built only when PERF_TIMER_LAP_EN is defined.
module ahb_perf_timer
  import ahb_perf_pkg::*;
#(
  parameter int NCORES   = 4,
  parameter int PRESCALE = 5_000_000
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_perf_timer_if.slave  bus,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5,
  output logic [6:0]       HEX6
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic              r_acc_valid;
  logic              r_acc_write;
  logic [2:0]        r_acc_off;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [PW-1:0]     r_pre;
  logic [3:0]        r_ds;
  logic [5:0]        r_sec;
  logic [3:0]        r_min;
  logic              r_ovf;
  logic [NCORES-1:0] r_done_mask;
  logic [3:0]        r_pixel;

  logic              w_wr;
  logic              w_rd;
  logic              w_start;
  logic              w_stop;
  logic              w_clear;
  logic              w_done_wr;
  logic [NCORES-1:0] w_done_bits;
  logic              w_enter_run;
  logic              w_running;
  logic              w_tick;
  logic [5:0]        w_done_count;
  logic [31:0]       w_time_word;
  logic [31:0]       w_status_word;
  logic [31:0]       w_lap_word;
  logic [3:0]        w_sec_ones;
  logic [3:0]        w_sec_tens;
  logic [3:0]        w_cnt_ones;
  logic [3:0]        w_cnt_tens;
  logic              w_unused;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_acc_valid <= 1'b0;
      r_acc_write <= 1'b0;
      r_acc_off   <= '0;
    end else begin
      r_acc_valid <= bus.HSEL && bus.HREADY && (bus.HTRANS != HTRANS_IDLE);
      r_acc_write <= bus.HWRITE;
      r_acc_off   <= bus.HADDR[4:2];
    end
  end

  assign w_wr        = r_acc_valid && r_acc_write;
  assign w_rd        = r_acc_valid && !r_acc_write;
  assign w_start     = w_wr && (r_acc_off == REG_CTRL) && bus.HWDATA[CTRL_START];
  assign w_stop      = w_wr && (r_acc_off == REG_CTRL) && bus.HWDATA[CTRL_STOP];
  assign w_clear     = w_wr && (r_acc_off == REG_CTRL) && bus.HWDATA[CTRL_CLEAR];
  assign w_running   = (r_state == RUNNING);
  assign w_done_wr   = w_wr && (r_acc_off == REG_DONE) && w_running;
  assign w_done_bits = bus.HWDATA[NCORES-1:0];
  assign w_tick      = w_running && (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Stop beats start; a full done_mask is judged on the registered value.
  always_comb begin
    w_state_nxt = r_state;
    w_enter_run = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start && !w_stop) begin
          w_state_nxt = RUNNING;
          w_enter_run = 1'b1;
        end
      end
      RUNNING: begin
        if (w_stop)             w_state_nxt = IDLE;
        else if (&r_done_mask)  w_state_nxt = FINISHED;
      end
      FINISHED: begin
        if (w_start && !w_stop) begin
          w_state_nxt = RUNNING;
          w_enter_run = 1'b1;
        end else if (w_clear) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)           r_pre <= '0;
    else if (w_enter_run) r_pre <= '0;
    else if (w_running)   r_pre <= w_tick ? '0 : r_pre + PW'(1);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ds  <= '0;
      r_sec <= '0;
      r_min <= '0;
      r_ovf <= 1'b0;
    end else if (w_enter_run || w_clear) begin
      r_ds  <= '0;
      r_sec <= '0;
      r_min <= '0;
      r_ovf <= 1'b0;
    end else if (w_tick) begin
      if (r_ds != 4'd9) begin
        r_ds <= r_ds + 4'd1;
      end else begin
        r_ds <= '0;
        if (r_sec != 6'd59) begin
          r_sec <= r_sec + 6'd1;
        end else begin
          r_sec <= '0;
          if (r_min != 4'd9) begin
            r_min <= r_min + 4'd1;
          end else begin
            r_min <= '0;
            r_ovf <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                        r_done_mask <= '0;
    else if (w_enter_run || w_clear)   r_done_mask <= '0;
    else if (w_done_wr)                r_done_mask <= r_done_mask | w_done_bits;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                                   r_pixel <= '0;
    else if (w_wr && (r_acc_off == REG_PIXEL))    r_pixel <= bus.HWDATA[3:0];
  end

  assign w_time_word = pack_time(r_ds, r_sec, r_min);

`ifdef PERF_TIMER_LAP_EN
  logic [19:0]       r_lap;
  logic [NCORES-1:0] w_new_bits;

  assign w_new_bits = w_done_bits & ~r_done_mask;

  // Only a DONE write that adds a core snapshots the pre-tick time.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                          r_lap <= '0;
    else if (w_enter_run || w_clear)     r_lap <= '0;
    else if (w_done_wr && |w_new_bits)   r_lap <= w_time_word[19:0];
  end

  assign w_lap_word = {12'd0, r_lap};
`else
  assign w_lap_word = '0;
`endif

  always_comb begin
    w_done_count = '0;
    for (int i = 0; i < NCORES; i++) w_done_count = w_done_count + 6'(r_done_mask[i]);
  end

  assign w_status_word = {14'd0, r_state, 2'd0, w_done_count, 6'd0, r_ovf, w_running};

  always_comb begin
    bus.HRDATA = '0;
    if (w_rd) begin
      case (r_acc_off)
        REG_STATUS: bus.HRDATA = w_status_word;
        REG_TIME:   bus.HRDATA = w_time_word;
        REG_LAP:    bus.HRDATA = w_lap_word;
        REG_PIXEL:  bus.HRDATA = {28'd0, r_pixel};
        default:    bus.HRDATA = '0;
      endcase
    end
  end

  assign bus.HREADYOUT = 1'b1;

  assign w_sec_ones = 4'(r_sec % 6'd10);
  assign w_sec_tens = 4'(r_sec / 6'd10);
  assign w_cnt_ones = 4'(w_done_count % 6'd10);
  assign w_cnt_tens = 4'(w_done_count / 6'd10);

  perf_seg_digit u_hex0 (.i_val(r_ds),       .o_seg(HEX0));
  perf_seg_digit u_hex1 (.i_val(w_sec_ones), .o_seg(HEX1));
  perf_seg_digit u_hex2 (.i_val(w_sec_tens), .o_seg(HEX2));
  perf_seg_digit u_hex3 (.i_val(r_min),      .o_seg(HEX3));
  perf_seg_digit u_hex4 (.i_val(w_cnt_ones), .o_seg(HEX4));
  perf_seg_digit u_hex5 (.i_val(w_cnt_tens), .o_seg(HEX5));
  perf_seg_digit u_hex6 (.i_val(r_pixel),    .o_seg(HEX6));

  // Bus fields outside the word decode are intentionally ignored.
  assign w_unused = ^{bus.HSIZE, bus.HADDR, bus.HWDATA};

endmodule

// File: tb/tb_ahb_perf_timer.sv
// Randomized scoreboard bench for ahb_perf_timer (PRESCALE=4, NCORES=4);
// the reference model tracks elapsed time as a single decisecond count.
module tb_ahb_perf_timer;

  localparam int P  = 4;
  localparam int NC = 4;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6;

  ahb_perf_timer_if bus();

  ahb_perf_timer #(.NCORES(NC), .PRESCALE(P)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2),
    .HEX3  (HEX3),
    .HEX4  (HEX4),
    .HEX5  (HEX5),
    .HEX6  (HEX6)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state 0 idle / 1 running / 2 finished, time as total deciseconds.
  int         m_state;
  int         m_pre;
  int         m_t;
  int         m_lap_t;
  logic       m_ovf;
  logic [3:0] m_mask;
  logic [3:0] m_pix;

  bit          dp_wr = 1'b0;
  bit          dp_rd = 1'b0;
  logic [2:0]  dp_off = '0;
  logic [31:0] dp_data = '0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h01;
    endcase
  endfunction

  function automatic logic [31:0] time_word(input int t);
    return {12'd0, 4'(t / 600), 2'd0, 6'((t / 10) % 60), 4'd0, 4'(t % 10)};
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd2: return {14'd0, 2'(m_state), 2'd0, 6'($countones(m_mask)), 6'd0, m_ovf, (m_state == 1)};
      3'd3: return time_word(m_t);
`ifdef PERF_TIMER_LAP_EN
      3'd4: return time_word(m_lap_t);
`endif
      3'd5: return {28'd0, m_pix};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] model_hex();
    int s = (m_t / 10) % 60;
    int c = $countones(m_mask);
    return {15'd0, seg(int'(m_pix)), seg(c / 10), seg(c % 10), seg(m_t / 600),
            seg(s / 10), seg(s % 10), seg(m_t % 10)};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_pre = 0; m_t = 0; m_lap_t = 0;
    m_ovf = 1'b0; m_mask = '0; m_pix = '0;
  endfunction

  // Applies one clock edge, including any write whose data phase ends here.
  function automatic void model_edge();
    bit start, stop, clr, done_wr, tick, enter;
    int nstate;
    logic [3:0] bits;
    start   = dp_wr && dp_off == 3'd0 && dp_data[0];
    stop    = dp_wr && dp_off == 3'd0 && dp_data[1];
    clr     = dp_wr && dp_off == 3'd0 && dp_data[2];
    done_wr = dp_wr && dp_off == 3'd1 && m_state == 1;
    bits    = dp_data[3:0];
    tick    = (m_state == 1) && (m_pre == P - 1);
    nstate  = m_state;
    enter   = 1'b0;
    case (m_state)
      0: if (start && !stop) begin nstate = 1; enter = 1'b1; end
      1: if (stop) nstate = 0; else if (m_mask == 4'hF) nstate = 2;
      default: if (start && !stop) begin nstate = 1; enter = 1'b1; end
               else if (clr) nstate = 0;
    endcase
    if (enter) begin
      m_pre = 0; m_t = 0; m_mask = '0; m_lap_t = 0; m_ovf = 1'b0;
    end else begin
      if (m_state == 1) m_pre = (m_pre + 1) % P;
      if (clr) begin
        m_t = 0; m_mask = '0; m_lap_t = 0; m_ovf = 1'b0;
      end else begin
        if (done_wr) begin
          if ((bits & ~m_mask) != 4'd0) m_lap_t = m_t;
          m_mask = m_mask | bits;
        end
        if (tick) begin
          m_t = (m_t + 1) % 6000;
          if (m_t == 0) m_ovf = 1'b1;
        end
      end
    end
    if (dp_wr && dp_off == 3'd5) m_pix = dp_data[3:0];
    m_state = nstate;
  endfunction

  task automatic step();
    @(posedge HCLK);
    model_edge();
    #1;
  endtask

  task automatic xfer(input bit wr, input logic [2:0] off, input logic [31:0] data);
    bus.HREADY = 1'b1;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HSIZE  = 3'b010;
    bus.HADDR  = ($urandom() & 32'hFFFF_FFE0) | {27'd0, off, 2'b00};
    step();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HWDATA = wr ? data : $urandom();
    dp_off     = off;
    if (wr) begin
      dp_wr   = 1'b1;
      dp_data = data;
    end else begin
      exp_q.push_back(model_read(off));
      dp_rd = 1'b1;
    end
    step();
    dp_wr = 1'b0;
    dp_rd = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    xfer(1'b1, off, data);
  endtask

  task automatic rd(input logic [2:0] off);
    xfer(1'b0, off, 32'd0);
  endtask

  // Idle cycles use assorted bus patterns that must not count as accesses.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.HWDATA = $urandom();
      bus.HADDR  = $urandom() & 32'hFFFF_FFFC;
      bus.HWRITE = 1'b1;
      case ($urandom_range(0, 3))
        0:       begin bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HREADY = 1'b1; end
        1:       begin bus.HSEL = 1'b0; bus.HTRANS = 2'b10; bus.HREADY = 1'b1; end
        2:       begin bus.HSEL = 1'b1; bus.HTRANS = 2'b00; bus.HREADY = 1'b1; end
        default: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HREADY = 1'b0; end
      endcase
      step();
    end
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HREADY = 1'b1;
    bus.HWRITE = 1'b0;
  endtask

  always @(negedge HCLK) begin
    if (dp_rd) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_no_expected: read data %0h with empty queue", bus.HRDATA);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check($sformatf("rd_off%0d", dp_off), bus.HRDATA, e);
      end
      check("hreadyout", bus.HREADYOUT, 1);
      check("hex_all", {15'd0, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, model_hex());
    end
  end

  initial begin
    model_reset();
    HRESET     = 1'b1;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h8;
    bus.HREADY = 1'b1;
    bus.HSIZE  = 3'b010;
    bus.HWDATA = '0;
    @(posedge HCLK);
    #1;
    check("rst_hrdata", bus.HRDATA, 0);
    check("rst_hreadyout", bus.HREADYOUT, 1);
    check("rst_hex0_5", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'h40}});
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    #2 HRESET = 1'b0;

    // Post-reset register contents.
    rd(3'd2); rd(3'd3); rd(3'd4);
    check("hex0_after_reset", HEX0, 7'h40);

    // Ten ticks of four cycles show one second.
    wr(3'd0, 32'h1);
    idle(40);
    check("hex0_1s", HEX0, 7'h40);
    check("hex1_1s", HEX1, 7'h79);
    check("hex2_1s", HEX2, 7'h40);
    rd(3'd3);

    // Completion reports, including a repeated bit, then the freeze.
    foreach (exp_q[i]) begin end
    begin
      logic [31:0] seq [4];
      seq = '{32'h1, 32'h1, 32'h6, 32'h8};
      for (int i = 0; i < 4; i++) begin
        wr(3'd1, seq[i]);
        rd(3'd2);
        idle($urandom_range(0, 5));
      end
    end
    rd(3'd2); rd(3'd3); rd(3'd4);
    idle(20);
    rd(3'd3); rd(3'd4);

    // Restart, stop with start+stop, then clear.
    wr(3'd0, 32'h1);
    idle($urandom_range(10, 30));
    wr(3'd0, 32'h3);
    rd(3'd2);
    idle(12);
    rd(3'd3);
    wr(3'd0, 32'h4);
    rd(3'd3); rd(3'd2);
    wr(3'd0, 32'h3);
    rd(3'd2);
    wr(3'd1, 32'h5);
    rd(3'd2);

    // 6000 ticks wrap 9:59.9 back to zero and set overflow.
    wr(3'd0, 32'h1);
    idle(6000 * P);
    check("hex0_3_wrap", {HEX3, HEX2, HEX1, HEX0}, {4{7'h40}});
    rd(3'd2); rd(3'd3);

    // Out-of-range pixel value.
    wr(3'd5, 32'hC);
    rd(3'd5);
    check("hex6_pixel12", HEX6, 7'h01);

    // Reset in the middle of a run.
    idle(7);
    #2 HRESET = 1'b1;
    model_reset();
    #1;
    check("midrst_hrdata", bus.HRDATA, 0);
    check("midrst_hex", {HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {7{7'h40}});
    @(posedge HCLK);
    #2 HRESET = 1'b0;
    rd(3'd2); rd(3'd3);
    idle(20);
    rd(3'd3);
    wr(3'd1, 32'h1);
    rd(3'd2); rd(3'd5);
    wr(3'd0, 32'h1);
    idle(10);
    rd(3'd3);

    // Randomized mix of all operations.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       wr(3'd0, 32'($urandom_range(0, 7)));
        1:       wr(3'd1, 32'(1) << $urandom_range(0, 3));
        2:       wr(3'd1, $urandom());
        3:       wr(3'd5, $urandom());
        4:       wr(3'($urandom_range(2, 7)), $urandom());
        9:       idle($urandom_range(0, 40));
        default: rd(3'($urandom_range(0, 7)));
      endcase
      idle($urandom_range(0, 3));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
